// File: rtl/rst_seq_sync_recover.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rst_seq_sync_recover
// Reset generator: the board reset asserts asynchronously and releases
// synchronously. All domains are then held for a minimum time, and the
// per-domain resets are released one at a time in index order. A synchronous
// software request restarts the whole sequence.
//
// Ports
//   clk_50m     in   1        system clock, single domain
//   rst_in      in   1        board reset, async active-high, may glitch
//   sw_rst_req  in   1        software reset request, sync active-high
//   rst_out     out  NUM_OUT  per-domain resets, active-high, bit 0 first
//   rst_done    out  1        every rst_out bit released
// -----------------------------------------------------------------------------
module rst_seq_sync_recover #(
  parameter int unsigned SYNC_STAGES = 2,   // 2..4
  parameter int unsigned NUM_OUT     = 4,   // 1..16
  parameter int unsigned HOLD_CYCLES = 16,  // >= 1
  parameter int unsigned STEP_CYCLES = 8    // >= 1
) (
  input  logic               clk_50m,
  input  logic               rst_in,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               rst_done
);

  localparam int unsigned MAX_CYC = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_rst;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic [IDX_W-1:0]       idx_q,   idx_d;
  logic [NUM_OUT-1:0]     rst_out_q, rst_out_d;
  logic                   done_q,  done_d;
  logic                   req_q;

  // Reset synchroniser: set asynchronously, drains zeros on each edge.
  always_ff @(posedge clk_50m or posedge rst_in) begin
    if (rst_in) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign sync_rst = sync_q[SYNC_STAGES-1];

  // Sequencer state; every output comes straight from these flops.
  always_ff @(posedge clk_50m or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
      req_q     <= sw_rst_req;
    end
  end

  // Next-state logic. A request seen on this edge freezes the sequencer (so a
  // release due on the same edge is dropped); the restart lands one edge later
  // through req_q.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;

    if (req_q) begin
      state_d   = ST_HOLD;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = '1;
      done_d    = 1'b0;
    end else if (!sw_rst_req) begin
      case (state_q)
        ST_HOLD: begin
          if (sync_rst) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            rst_out_d[0] = 1'b0;
            cnt_d        = '0;
            idx_d        = IDX_W'(1);
            if (NUM_OUT == 1) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
            for (int i = 0; i < NUM_OUT; i++) begin
              if (IDX_W'(i) == idx_q) begin
                rst_out_d[i] = 1'b0;
              end
            end
            cnt_d = '0;
            if (idx_q == IDX_W'(NUM_OUT - 1)) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_DONE: begin
          rst_out_d = '0;
          done_d    = 1'b1;
        end

        default: begin
          state_d   = ST_HOLD;
          cnt_d     = '0;
          idx_d     = '0;
          rst_out_d = '1;
          done_d    = 1'b0;
        end
      endcase
    end
  end

  assign rst_out  = rst_out_q;
  assign rst_done = done_q;

endmodule

// File: tb/tb_rst_seq_sync_recover.sv
`timescale 1ns/1ps
// Directed bench for rst_seq_sync_recover: expected output words are queued
// against absolute clock-edge numbers and compared on the following falling
// edge. A second instance covers the minimal parameter corner.
module tb_rst_seq_sync_recover;

  localparam int NOUT      = 4;
  localparam int STEP      = 8;
  // First release edge counted from the edge before E1: 2 sync stages + 16 hold.
  localparam int FIRST_REL = 18;

  typedef struct {
    int         edge_no;
    bit         sel;     // 0 = default instance, 1 = sweep instance
    logic [3:0] out;
    logic       done;
  } exp_t;

  logic       clk        = 1'b0;
  logic       rst_in     = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic [3:0] rst_out;
  logic       rst_done;

  logic       rst2 = 1'b1;
  logic       sw2  = 1'b0;
  logic [0:0] rst_out2;
  logic       rst_done2;

  int   checks   = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  exp_t sb_q[$];

  rst_seq_sync_recover dut (
    .clk_50m    (clk),
    .rst_in     (rst_in),
    .sw_rst_req (sw_rst_req),
    .rst_out    (rst_out),
    .rst_done   (rst_done)
  );

  rst_seq_sync_recover #(
    .SYNC_STAGES (3),
    .NUM_OUT     (1),
    .HOLD_CYCLES (1),
    .STEP_CYCLES (1)
  ) dut_sweep (
    .clk_50m    (clk),
    .rst_in     (rst2),
    .sw_rst_req (sw2),
    .rst_out    (rst_out2),
    .rst_done   (rst_done2)
  );

  always #10 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h edge=%0d", tag, obs, exp, edge_cnt);
    end
  endtask

  task automatic push(input int edge_no, input bit sel, input logic [3:0] out, input logic done);
    exp_t e;
    e.edge_no = edge_no;
    e.sel     = sel;
    e.out     = out;
    e.done    = done;
    sb_q.push_back(e);
  endtask

  // Expected default-instance outputs for edges base+k0 .. base+k1 of a
  // sequence whose first release lands on edge base+first_rel.
  task automatic push_seq(input int base, input int k0, input int k1, input int first_rel);
    for (int k = k0; k <= k1; k++) begin
      int         rel;
      logic [3:0] ones;
      ones = 4'b1111;
      rel  = (k < first_rel) ? 0 : 1 + (k - first_rel) / STEP;
      if (rel > NOUT) rel = NOUT;
      push(base + k, 1'b0, ones << rel, rel == NOUT);
    end
  endtask

  // Advance n falling edges; check release ordering and pop due expectations.
  task automatic run_edges(input int n);
    exp_t       e;
    logic [3:0] z;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      z = ~rst_out;
      check("order", 32'((z + 4'd1) & z), 32'd0);
      if (rst_done) check("done_all_low", 32'(rst_out), 32'd0);
      while (sb_q.size() > 0 && sb_q[0].edge_no <= edge_cnt) begin
        e = sb_q.pop_front();
        check("sb_edge", 32'(e.edge_no), 32'(edge_cnt));
        if (e.sel)
          check("sweep_out", 32'({rst_out2, rst_done2}), 32'({e.out[0], e.done}));
        else
          check("main_out", 32'({rst_out, rst_done}), 32'({e.out, e.done}));
      end
    end
  endtask

  initial begin
    int base;
    int w;

    // Power-on: reset held for 5 edges, released just before E1.
    for (int k = 1; k <= 5; k++) push(k, 1'b0, 4'hF, 1'b0);
    run_edges(5);
    rst_in = 1'b0;
    base   = edge_cnt;
    push_seq(base, 1, 30, FIRST_REL);
    run_edges(1);
    check("sync_e1", 32'(dut.sync_rst), 32'd1);
    run_edges(1);
    check("sync_e2", 32'(dut.sync_rst), 32'd0);
    run_edges(28);

    // 3 ns async pulse while rst_out = 1100.
    rst_in = 1'b1;
    #1;
    check("async_mid_release", 32'({rst_out, rst_done}), 32'h1E);
    #2;
    rst_in = 1'b0;
    sb_q.delete();
    base = edge_cnt;
    push_seq(base, 1, 42, FIRST_REL);
    run_edges(42);

    // One-cycle software request from DONE, sampled at edge S = base+1.
    base       = edge_cnt;
    sw_rst_req = 1'b1;
    push(base + 1, 1'b0, 4'h0, 1'b1);
    push_seq(base, 2, 42, FIRST_REL);
    run_edges(1);
    sw_rst_req = 1'b0;
    run_edges(41);

    // Request colliding with the rst_out[2] release edge, held 10 cycles.
    base       = edge_cnt;
    sw_rst_req = 1'b1;
    push(base + 1, 1'b0, 4'h0, 1'b1);
    push_seq(base, 2, 33, FIRST_REL);
    run_edges(1);
    sw_rst_req = 1'b0;
    run_edges(32);
    sw_rst_req = 1'b1;
    push(base + 34, 1'b0, 4'hC, 1'b0);
    for (int k = 35; k <= 44; k++) push(base + k, 1'b0, 4'hF, 1'b0);
    push_seq(base + 42, 3, 42, FIRST_REL);
    run_edges(10);
    sw_rst_req = 1'b0;
    run_edges(41);

    // Random-width rst_in glitches at random points of the sequence.
    for (int g = 0; g < 6; g++) begin
      w = int'($urandom_range(20, 1));
      #0.5 rst_in = 1'b1;
      #0.5 check("glitch_async", 32'({rst_out, rst_done}), 32'h1E);
      #(real'(w) - 0.5) rst_in = 1'b0;
      sb_q.delete();
      base = edge_cnt;
      push_seq(base, 1, 60, FIRST_REL);
      run_edges(int'($urandom_range(45, 3)));
    end
    run_edges(62);

    // Minimal-parameter instance: release and done together on E4.
    rst2 = 1'b0;
    base = edge_cnt;
    for (int k = 1; k <= 3; k++) push(base + k, 1'b1, 4'h1, 1'b0);
    for (int k = 4; k <= 6; k++) push(base + k, 1'b1, 4'h0, 1'b1);
    run_edges(6);

    check("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rst_seq_sync_recover.md
Name: rst_seq_sync_recover

Overview:
- Parametrised reset generator: asynchronous assertion, synchronous de-assertion, minimum hold stretch and staged per-domain release.
- Takes the board reset `rst_in` plus a synchronous software reset request.
- Drives NUM_OUT active-high reset outputs, released one at a time in index order, so downstream blocks come out of reset in a fixed sequence.
- Sits at top level directly after the clock source; every other block takes one `rst_out` bit.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for rst_in de-assertion; legal range 2..4.
- NUM_OUT, 4, number of reset outputs/domains; legal range 1..16.
- HOLD_CYCLES, 16, clk_50m cycles all outputs stay asserted after synchronised release; legal range ≥1.
- STEP_CYCLES, 8, clk_50m cycles between successive output releases; legal range ≥1.

Ports:
- clk_50m  input  1  system clock, single clock domain.
- rst_in  input  1  reset; asynchronous, active-high; may be glitchy or asynchronous to clk_50m.
- sw_rst_req  input  1  synchronous software reset request, active-high, level or pulse.
- rst_out  output  NUM_OUT  per-domain resets, active-high, registered; bit 0 releases first.
- rst_done  output  1  high when every rst_out bit is released; registered.

Behaviour:
- Reset (rst_in=1), asynchronous, no clock needed:
  - all synchroniser stages, every rst_out bit and the FSM go to their reset values immediately.
  - rst_out = all 1s, rst_done = 0, state = HOLD, counter = 0.
- Synchroniser:
  - SYNC_STAGES flops, asynchronously set by rst_in, shift in 0 each edge.
  - sync_rst = last stage.
  - rst_in falling before edge E1 gives sync_rst=0 after edge E(SYNC_STAGES).
- FSM states: HOLD, RELEASE, DONE. A single counter of width clog2(max(HOLD_CYCLES,STEP_CYCLES)+1) serves both HOLD and RELEASE.
- HOLD:
  - while sync_rst=1, counter holds 0.
  - once sync_rst=0, counter increments every edge.
  - on the edge where counter==HOLD_CYCLES-1: clear rst_out[0], counter←0, idx←1.
  - if NUM_OUT==1, that edge also sets rst_done←1 and goes to DONE; otherwise go to RELEASE.
- RELEASE:
  - counter increments every edge.
  - on the edge where counter==STEP_CYCLES-1: clear rst_out[idx], counter←0, idx←idx+1.
  - when idx==NUM_OUT-1 is cleared, set rst_done←1 on the same edge and go to DONE.
- DONE: all rst_out=0, rst_done=1; stays here until a reset or a request.
- sw_rst_req=1 sampled at an edge in any state:
  - next edge: rst_out←all 1s, rst_done←0, counter←0, idx←0, state←HOLD.
  - sync_rst is already 0, so the hold count starts on the next edge.
  - a request held high keeps the block in HOLD with counter 0; counting starts on the first edge after it drops.
- Simultaneous events:
  - rst_in overrides sw_rst_req and everything else.
  - sw_rst_req overrides a release scheduled on the same edge: no bit is released on that edge.
- rst_in re-asserted mid-RELEASE or in DONE: all outputs return to 1 asynchronously within the same cycle; the full sequence restarts.
- Output monotonicity within one sequence:
  - rst_out bits only fall in index order.
  - a higher-index bit is never 0 while a lower-index bit is 1.
  - no output glitches; all outputs come straight from flops.
- Total release latency from sync_rst=0 to rst_done=1: HOLD_CYCLES + (NUM_OUT-1)·STEP_CYCLES edges.

Test Plan:
- Power-on with defaults:
  - rst_in=1 for 5 cycles, then falls just before edge E1.
  - Required: sync_rst=0 after E2.
  - Required: rst_out 4'b1110 after E18, 4'b1100 after E26, 4'b1000 after E34, 4'b0000 after E42.
  - Required: rst_done=1 after E42 and 0 at all times before.
- Async assert mid-release:
  - In RELEASE with rst_out=4'b1100, pulse rst_in high for 3 ns between clock edges.
  - Required: rst_out=4'b1111 and rst_done=0 before the next edge.
  - Required: the full 42-edge sequence repeats from the rst_in fall.
- Software reset from DONE:
  - sw_rst_req=1 for one cycle at edge S.
  - Required: rst_out=4'b1111 after S+1, 4'b1110 after S+17, rst_done=1 after S+41.
- Held request with a colliding release:
  - Assert sw_rst_req on exactly the edge scheduled to clear rst_out[2]; keep it high 10 cycles, then drop it.
  - Required: rst_out[2] never reads 0 on that edge.
  - Required: outputs stay 4'b1111 for the whole request; HOLD_CYCLES counting starts after the drop.
- Parameter sweep:
  - SYNC_STAGES=3, NUM_OUT=1, HOLD_CYCLES=1, STEP_CYCLES=1.
  - Required: rst_out[0] and rst_done change on the same edge, E3+1 after the rst_in fall.
- Glitchy rst_in:
  - Random 1–20 ns high pulses on rst_in during the sequence.
  - Required: every pulse restarts the sequence; the monotonic release-order assertion never fires.
